// File: rtl/mem_pkg.sv
// Shared memory-side types for the core data port: store buffer entry layout
// and default sizing.
package mem_pkg;
  localparam int SB_AW        = 32;
  localparam int SB_DW        = 32;
  localparam int SB_DEPTH_DEF = 4;
  localparam int SB_PTR_W     = $clog2(SB_DEPTH_DEF);

  typedef struct packed {
    logic [SB_AW-3:0] waddr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;
endpackage

// File: rtl/store_buffer_if.sv
// Backing RAM port: combinational read channel plus ready/valid write channel.
interface store_buffer_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rd;
  logic          mem_wvalid;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wready;

  modport master (
    output mem_raddr, mem_wvalid, mem_waddr, mem_wdata,
    input  mem_rd, mem_wready
  );

  modport slave (
    input  mem_raddr, mem_wvalid, mem_waddr, mem_wdata,
    output mem_rd, mem_wready
  );
endinterface

// File: rtl/sb_fwd_match.sv
// Load forwarding lookup: returns the youngest valid buffer entry whose word
// address matches the query.
module sb_fwd_match
  import mem_pkg::*;
#(
  parameter  int DEPTH = SB_DEPTH_DEF,
  localparam int PW    = $clog2(DEPTH)
) (
  input  sb_entry_t              entries [DEPTH],
  input  logic      [DEPTH-1:0]  valid,
  input  logic      [PW-1:0]     tail,
  input  logic      [SB_AW-3:0]  qaddr,
  output logic                   hit,
  output logic      [SB_DW-1:0]  hit_data
);
  logic [PW-1:0] idx;

  // Walk oldest to youngest (tail-DEPTH .. tail-1) so the last match wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = tail - PW'(k);
      if (valid[idx] && entries[idx].waddr == qaddr) begin
        hit      = 1'b1;
        hit_data = entries[idx].data;
      end
    end
  end
endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the core data port and data RAM: in-order drain,
// load forwarding from pending stores, stall when full.
module store_buffer
  import mem_pkg::*;
#(
  parameter  int DEPTH = SB_DEPTH_DEF,
  parameter  int DW    = SB_DW,
  parameter  int AW    = SB_AW,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wd,
  output logic [DW-1:0] cpu_rd,
  output logic          stall,
  output logic          empty,
  output logic [CW-1:0] count,
  store_buffer_if.master mem
);
  sb_entry_t            entries [DEPTH];
  logic [DEPTH-1:0]     valid;
  logic [PW-1:0]        head;
  logic [PW-1:0]        tail;
  logic                 full;
  logic                 accept;
  logic                 drain;
  logic                 fwd_hit;
  logic [SB_DW-1:0]     fwd_data;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign accept = cpu_we & ~full;
  assign stall  = cpu_we & full;
  assign drain  = mem.mem_wvalid & mem.mem_wready;

  assign mem.mem_raddr  = cpu_addr;
  assign mem.mem_wvalid = ~empty;
  assign mem.mem_waddr  = {entries[head].waddr, 2'b00};
  assign mem.mem_wdata  = entries[head].data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (accept) begin
        tail        <= tail + 1'b1;
        valid[tail] <= 1'b1;
      end
      if (drain) begin
        head        <= head + 1'b1;
        valid[head] <= 1'b0;
      end
      case ({accept, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry payload is don't-care until its valid bit is set, so it is not reset.
  always_ff @(posedge clk) begin
    if (accept) entries[tail] <= '{waddr: cpu_addr[AW-1:2], data: cpu_wd};
  end

  sb_fwd_match #(.DEPTH(DEPTH)) u_fwd (
    .entries  (entries),
    .valid    (valid),
    .tail     (tail),
    .qaddr    (cpu_addr[AW-1:2]),
    .hit      (fwd_hit),
    .hit_data (fwd_data)
  );

  assign cpu_rd = fwd_hit ? fwd_data : mem.mem_rd;

  always @(posedge clk) begin
    if (reset) begin
      assert (!(accept && full));
      assert (!(drain && empty));
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: drain handshake, full stall, forwarding,
// pointer wrap, hold-while-not-ready and async reset flush.
module tb_store_buffer;
  logic        clk;
  logic        reset;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wd;
  logic [31:0] cpu_rd;
  logic        stall;
  logic        empty;
  logic [2:0]  count;
  int          checks;
  int          errors;

  store_buffer_if #(.AW(32), .DW(32)) mem_bus ();

  store_buffer dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wd   (cpu_wd),
    .cpu_rd   (cpu_rd),
    .stall    (stall),
    .empty    (empty),
    .count    (count),
    .mem      (mem_bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    cpu_we   = 1'b1;
    cpu_addr = a;
    cpu_wd   = d;
  endtask

  logic [31:0] exp_addr [4];
  logic [31:0] exp_data [4];

  initial begin
    checks             = 0;
    errors             = 0;
    reset              = 1'b0;
    cpu_we             = 1'b0;
    cpu_addr           = '0;
    cpu_wd             = '0;
    mem_bus.mem_rd     = '0;
    mem_bus.mem_wready = 1'b0;
    tick();
    tick();
    chk("rst_wvalid", mem_bus.mem_wvalid, 1'b0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_stall", stall, 1'b0);
    chk("rst_count", count, 3'd0);
    reset = 1'b1;

    // single store, immediate drain
    mem_bus.mem_wready = 1'b1;
    store(32'h10, 32'hDEAD_BEEF);
    #1;
    chk("t1_stall", stall, 1'b0);
    chk("t1_no_flowthru", mem_bus.mem_wvalid, 1'b0);
    chk("t1_raddr", mem_bus.mem_raddr, 32'h10);
    tick();
    cpu_we = 1'b0;
    #1;
    chk("t1_wvalid", mem_bus.mem_wvalid, 1'b1);
    chk("t1_waddr", mem_bus.mem_waddr, 32'h10);
    chk("t1_wdata", mem_bus.mem_wdata, 32'hDEAD_BEEF);
    chk("t1_count1", count, 3'd1);
    tick();
    chk("t1_count0", count, 3'd0);
    chk("t1_empty", empty, 1'b1);
    chk("t1_wvalid0", mem_bus.mem_wvalid, 1'b0);

    // fill, stall on fifth, one-cycle drain frees a slot
    mem_bus.mem_wready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      store(32'(i * 4), 32'h100 + 32'(i));
      tick();
    end
    store(32'h30, 32'h555);
    #1;
    chk("t2_count4", count, 3'd4);
    chk("t2_stall", stall, 1'b1);
    chk("t2_head", mem_bus.mem_waddr, 32'h0);
    mem_bus.mem_wready = 1'b1;
    #1;
    chk("t2_stall_no_bypass", stall, 1'b1);
    tick();
    mem_bus.mem_wready = 1'b0;
    #1;
    chk("t2_count3", count, 3'd3);
    chk("t2_stall_clear", stall, 1'b0);
    chk("t2_head4", mem_bus.mem_waddr, 32'h4);
    tick();
    cpu_we = 1'b0;
    chk("t2_count_refill", count, 3'd4);
    exp_addr = '{32'h4, 32'h8, 32'hC, 32'h30};
    exp_data = '{32'h101, 32'h102, 32'h103, 32'h555};
    mem_bus.mem_wready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_order_addr", mem_bus.mem_waddr, exp_addr[i]);
      chk("t2_order_data", mem_bus.mem_wdata, exp_data[i]);
      tick();
    end
    chk("t2_empty", empty, 1'b1);

    // load forwarding, youngest wins, drain-cycle entry still forwards
    mem_bus.mem_wready = 1'b0;
    store(32'h20, 32'h1);
    tick();
    store(32'h20, 32'h2);
    tick();
    cpu_we         = 1'b0;
    cpu_addr       = 32'h20;
    mem_bus.mem_rd = 32'h99;
    #1;
    chk("t3_fwd_young", cpu_rd, 32'h2);
    cpu_addr       = 32'h24;
    mem_bus.mem_rd = 32'h55;
    #1;
    chk("t3_miss", cpu_rd, 32'h55);
    cpu_addr       = 32'h20;
    mem_bus.mem_wready = 1'b1;
    tick();
    chk("t3_count1", count, 3'd1);
    chk("t3_fwd_draining", cpu_rd, 32'h2);
    tick();
    mem_bus.mem_rd = 32'h77;
    #1;
    chk("t3_after_drain", cpu_rd, 32'h77);

    // back-to-back stores for 3*DEPTH cycles: wrap, no stall, in order
    for (int i = 0; i < 12; i++) begin
      store(32'h100 + 32'(4 * i), 32'(i));
      #1;
      chk("t4_stall", stall, 1'b0);
      chk("t4_count", count, (i == 0) ? 3'd0 : 3'd1);
      if (i > 0) begin
        chk("t4_waddr", mem_bus.mem_waddr, 32'h100 + 32'(4 * (i - 1)));
        chk("t4_wdata", mem_bus.mem_wdata, 32'(i - 1));
      end
      tick();
    end
    cpu_we = 1'b0;
    #1;
    chk("t4_last_addr", mem_bus.mem_waddr, 32'h12C);
    chk("t4_last_data", mem_bus.mem_wdata, 32'd11);
    tick();
    chk("t4_empty", empty, 1'b1);

    // head holds while not ready
    mem_bus.mem_wready = 1'b0;
    store(32'h40, 32'hA);
    tick();
    store(32'h44, 32'hB);
    tick();
    cpu_we = 1'b0;
    exp_addr = '{32'h40, 32'h40, 32'h44, 32'h44};
    exp_data = '{32'hA, 32'hA, 32'hB, 32'hB};
    for (int i = 0; i < 4; i++) begin
      mem_bus.mem_wready = (i % 2) == 1;
      #1;
      chk("t5_wvalid", mem_bus.mem_wvalid, 1'b1);
      chk("t5_hold_addr", mem_bus.mem_waddr, exp_addr[i]);
      chk("t5_hold_data", mem_bus.mem_wdata, exp_data[i]);
      tick();
    end
    chk("t5_empty", empty, 1'b1);

    // async reset flushes pending stores
    mem_bus.mem_wready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      store(32'h80 + 32'(4 * i), 32'hF0 + 32'(i));
      tick();
    end
    cpu_we = 1'b0;
    chk("t6_count3", count, 3'd3);
    reset = 1'b0;
    #1;
    chk("t6_wvalid_async", mem_bus.mem_wvalid, 1'b0);
    chk("t6_empty_async", empty, 1'b1);
    chk("t6_count_async", count, 3'd0);
    tick();
    reset              = 1'b1;
    mem_bus.mem_wready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_no_stale", mem_bus.mem_wvalid, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
